// File: rtl/pcm1702_sample_scheduler_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pcm1702_sample_scheduler_if : upstream valid/ready and serializer start/done
// Revision: 1.0
// -----------------------------------------------------------------------------
interface pcm1702_sample_scheduler_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        dac_sample_rdy;
    logic [15:0] dac_data;
    logic        dac_shift_done;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output dac_sample_rdy,
        output dac_data,
        input  dac_shift_done
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  dac_sample_rdy,
        input  dac_data,
        output dac_shift_done
    );
endinterface
`default_nettype wire

// File: rtl/pcm1702_sample_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pcm1702_sample_scheduler : fixed-period sample issue with zero-order hold
// Revision: 1.0
// -----------------------------------------------------------------------------
module pcm1702_sample_scheduler #(
    parameter int PERIOD  = 128,
    parameter int TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_flags,
    pcm1702_sample_scheduler_if.slave bus,
    output logic                      busy,
    output logic                      tick,
    output logic                      underrun,
    output logic                      overrun,
    output logic                      fault
);
    localparam int                TCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0]       CNT_LAST  = 16'(PERIOD - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       cnt;
    logic [15:0]       hold_reg;
    logic [15:0]       data_reg;
    logic              hold_full;
    logic              hold_full_nxt;
    logic              ready_reg;
    logic [TCNT_W-1:0] tcnt;
    logic              accept;
    logic              drain;
    logic              starve;
    logic              drop;
    logic              expire;

    assign tick               = en && (cnt == CNT_LAST);
    assign accept             = bus.in_valid && ready_reg;
    assign busy               = (state != IDLE);
    assign bus.dac_sample_rdy = (state == ISSUE);
    assign bus.in_ready       = ready_reg;
    assign bus.dac_data       = data_reg;

    // Fill and drain are mutually exclusive: a fill needs an empty register.
    assign hold_full_nxt = accept ? 1'b1 : (drain ? 1'b0 : hold_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drain     = 1'b0;
        starve    = 1'b0;
        drop      = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = ISSUE;
                    drain     = hold_full;
                    starve    = !hold_full;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
                drop      = tick;
            end
            WAIT_DONE: begin
                drop = tick;
                if (bus.dac_shift_done) begin
                    state_nxt = IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    state_nxt = IDLE;
                    expire    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            tcnt      <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            ready_reg <= 1'b0;
            data_reg  <= '0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            if ((state == WAIT_DONE) && (state_nxt == WAIT_DONE)) begin
                tcnt <= tcnt + TCNT_W'(1);
            end else begin
                tcnt <= '0;
            end

            if (accept) begin
                hold_reg <= bus.in_data;
            end
            if (drain) begin
                data_reg <= hold_reg;
            end
            hold_full <= hold_full_nxt;
            ready_reg <= !hold_full_nxt;

            // A flag event outranks a simultaneous clear.
            underrun <= starve | (underrun & !clr_flags);
            overrun  <= drop   | (overrun  & !clr_flags);
            fault    <= expire | (fault    & !clr_flags);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pcm1702_sample_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pcm1702_sample_scheduler : vector table, corner sequences, random + model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_pcm1702_sample_scheduler;
    localparam int PERIOD  = 64;
    localparam int TIMEOUT = 256;
    localparam int BIG     = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clr_flags;
    logic busy, tick, underrun, overrun, fault;

    pcm1702_sample_scheduler_if bus ();

    pcm1702_sample_scheduler #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_flags(clr_flags), .bus(bus),
        .busy(busy), .tick(tick), .underrun(underrun), .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Serializer: completion pulse a programmable number of cycles after start (0 = never).
    int ser_delay = 40;
    int ser_d;
    bit rand_mode = 1'b0;
    int done_at   = -1;
    always @(negedge clk) begin
        if (!rst) begin
            done_at = -1;
        end else if (bus.dac_sample_rdy === 1'b1) begin
            ser_d = ser_delay;
            if (rand_mode) ser_d = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 90));
            done_at = (ser_d > 0) ? cyc + ser_d : -1;
        end
    end
    always @(posedge clk) begin
        #1;
        bus.dac_shift_done = (cyc == done_at);
    end

    // Reference model: transfers tracked as [start, end) cycle windows, ticks from elapsed en time.
    bit          m_act, m_full, m_rdy_ok, m_u, m_o, m_f;
    logic [15:0] m_hold, m_data;
    int          m_start, m_end, en_run;
    bit          e_tick, e_busy, e_rdy, e_ready, su, so, sf;
    bit          seen_ready;

    always @(negedge clk) begin
        seen_ready = bus.in_ready;
        if (!rst) begin
            m_act = 0; m_full = 0; m_rdy_ok = 0; m_u = 0; m_o = 0; m_f = 0;
            m_hold = '0; m_data = '0; m_start = 0; m_end = 0; en_run = 0;
        end
        e_tick  = en && (((en_run + 1) % PERIOD) == 0);
        e_busy  = m_act && (cyc >= m_start) && (cyc < m_end);
        e_rdy   = m_act && (cyc == m_start);
        e_ready = m_rdy_ok && !m_full;
        check("model_tick",       32'(tick),               32'(e_tick));
        check("model_sample_rdy", 32'(bus.dac_sample_rdy), 32'(e_rdy));
        check("model_busy",       32'(busy),               32'(e_busy));
        check("model_in_ready",   32'(bus.in_ready),       32'(e_ready));
        check("model_dac_data",   32'(bus.dac_data),       32'(m_data));
        check("model_underrun",   32'(underrun),           32'(m_u));
        check("model_overrun",    32'(overrun),            32'(m_o));
        check("model_fault",      32'(fault),              32'(m_f));
        if (rst) begin
            su = 0; so = 0; sf = 0;
            if (e_busy && cyc > m_start) begin
                if (bus.dac_shift_done) begin
                    m_end = cyc + 1;
                end else if (cyc == m_start + TIMEOUT) begin
                    m_end = cyc + 1;
                    sf = 1;
                end
            end
            if (e_tick) begin
                if (e_busy) begin
                    so = 1;
                end else begin
                    m_act = 1; m_start = cyc + 1; m_end = BIG;
                    if (m_full) begin
                        m_data = m_hold;
                        m_full = 0;
                    end else begin
                        su = 1;
                    end
                end
            end
            if (bus.in_valid && e_ready) begin
                m_hold = bus.in_data;
                m_full = 1;
            end
            m_u = su | (m_u & !clr_flags);
            m_o = so | (m_o & !clr_flags);
            m_f = sf | (m_f & !clr_flags);
            en_run   = en ? en_run + 1 : 0;
            m_rdy_ok = 1;
        end
    end

    logic [15:0] pulse_data;
    logic        pulse_u, pulse_o, pulse_f;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_pulse(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk);
            if (bus.dac_sample_rdy === 1'b1) begin
                at = cyc;
                pulse_data = bus.dac_data;
                pulse_u = underrun; pulse_o = overrun; pulse_f = fault;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL pulse_wait: no dac_sample_rdy within %0d cycles (cycle %0d)", limit, cyc);
        end
        step();
    endtask

    task automatic offer(input logic [15:0] d);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 4 * PERIOD && !ok; i++) begin
            @(negedge clk);
            ok = (bus.in_ready === 1'b1);
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL offer_timeout: sample %0h never accepted", d);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),       0);
        check({tag, "_sample_rdy"}, 32'(bus.dac_sample_rdy), 0);
        check({tag, "_busy"},       32'(busy),               0);
        check({tag, "_tick"},       32'(tick),               0);
        check({tag, "_dac_data"},   32'(bus.dac_data),       0);
        check({tag, "_underrun"},   32'(underrun),           0);
        check({tag, "_overrun"},    32'(overrun),            0);
        check({tag, "_fault"},      32'(fault),              0);
    endtask

    typedef struct {
        bit          supply;
        logic [15:0] din;
        logic [15:0] exp_data;
        int          exp_gap;
        bit          exp_under;
    } vec_t;

    vec_t vecs[6];
    int   at, prev, fall, npulse, e_start, r_cyc;
    int   p6, p7, p9, p10;

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 16'h1234, PERIOD, 1'b0};
        vecs[1] = '{1'b1, 16'h8000, 16'h8000, PERIOD, 1'b0};
        vecs[2] = '{1'b1, 16'h7FFF, 16'h7FFF, PERIOD, 1'b0};
        vecs[3] = '{1'b1, 16'h0ABC, 16'h0ABC, PERIOD, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 16'h0ABC, PERIOD, 1'b1};
        vecs[5] = '{1'b1, 16'h5555, 16'h5555, PERIOD, 1'b1};

        rst = 1'b0; en = 1'b0; clr_flags = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) step();
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b1;
        step(); step();
        en = 1'b1;
        e_start = cyc;

        prev = e_start;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].supply) offer(vecs[i].din);
            wait_pulse(3 * PERIOD, at);
            check($sformatf("vec%0d_data", i),     32'(pulse_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_gap", i),      at - prev,       vecs[i].exp_gap);
            check($sformatf("vec%0d_underrun", i), 32'(pulse_u),    32'(vecs[i].exp_under));
            check($sformatf("vec%0d_overrun", i),  32'(pulse_o),    0);
            check($sformatf("vec%0d_fault", i),    32'(pulse_f),    0);
            prev = at;
        end

        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        @(negedge clk);
        check("clr_underrun", 32'(underrun), 0);
        step();

        // Clear coincides with an underrun tick: the set must win.
        wait_until(prev + PERIOD - 1);
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        @(negedge clk);
        check("sim_clr_pulse",    32'(bus.dac_sample_rdy), 1);
        check("sim_clr_underrun", 32'(underrun),           1);
        check("sim_clr_zoh_data", 32'(bus.dac_data),       32'h5555);
        p6 = cyc;
        step();

        ser_delay = 70;
        offer(16'h1111);
        wait_pulse(3 * PERIOD, p7);
        check("ovr_first_gap",  p7 - p6, PERIOD);
        check("ovr_first_data", 32'(pulse_data), 32'h1111);
        ser_delay = 40;
        offer(16'h2222);
        wait_until(p7 + PERIOD);
        @(negedge clk);
        check("ovr_flag",    32'(overrun),            1);
        check("ovr_dropped", 32'(bus.dac_sample_rdy), 0);
        step();
        wait_pulse(3 * PERIOD, at);
        check("ovr_next_gap",  at - p7, 2 * PERIOD);
        check("ovr_next_data", 32'(pulse_data), 32'h2222);

        ser_delay = 0;
        wait_pulse(3 * PERIOD, p9);
        ser_delay = 40;
        fall = -1;
        for (int i = 0; i < 2 * TIMEOUT && fall < 0; i++) begin
            @(negedge clk);
            if (!busy) fall = cyc;
        end
        check("timeout_idle_cycle", fall - p9, TIMEOUT + 1);
        check("timeout_fault",      32'(fault), 1);
        step();

        wait_pulse(3 * PERIOD, p10);
        wait_until(p10 + 5);
        en = 1'b0;
        fall = -1;
        for (int i = 0; i < 2 * TIMEOUT && fall < 0; i++) begin
            @(negedge clk);
            if (!busy) fall = cyc;
        end
        check("en_drop_complete", fall - p10, 41);
        npulse = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (bus.dac_sample_rdy === 1'b1) npulse++;
        end
        check("en_drop_no_pulse", npulse, 0);
        step();

        en = 1'b1;
        e_start = cyc;
        offer(16'h3333);
        wait_pulse(3 * PERIOD, at);
        check("rst_pre_gap",  at - e_start, PERIOD);
        check("rst_pre_data", 32'(pulse_data), 32'h3333);
        wait_until(at + 10);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        step(); step(); step();
        rst = 1'b1;
        r_cyc = cyc;
        npulse = 0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            @(negedge clk);
            if (bus.dac_sample_rdy === 1'b1) npulse++;
        end
        check("rst_no_early_pulse", npulse, 0);
        step();
        wait_pulse(3 * PERIOD, at);
        check("rst_first_gap",      at - r_cyc, PERIOD);
        check("rst_first_data",     32'(pulse_data), 0);
        check("rst_first_underrun", 32'(pulse_u), 1);

        rand_mode = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 399) == 0) en = !en;
            clr_flags = ($urandom_range(0, 49) == 0);
            if (!(bus.in_valid && !seen_ready)) begin
                bus.in_valid = ($urandom_range(0, 2) == 0);
                bus.in_data  = 16'($urandom);
            end
            step();
        end
        rand_mode    = 1'b0;
        en           = 1'b0;
        clr_flags    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (300) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pcm1702_sample_scheduler.md
# pcm1702_sample_scheduler

Sample-rate scheduler between the FOH interpolator output and the `pcm1702_interface_edges` serializer. It generates the fixed output sample period, buffers one upstream sample in a valid/ready holding register, and issues one `sample_rdy` pulse per period. It holds `data` stable until the serializer reports `shift_done`. On starvation it repeats the last sample (zero-order hold), and it flags underrun, overrun and a stuck-serializer timeout.

## Interface
- `PERIOD`, default 128: clk cycles per output sample. Legal range 64..65535. The serializer needs about 40 cycles per word.
- `TIMEOUT`, default 256: maximum cycles spent in WAIT_DONE before the transfer is abandoned. Must be greater than PERIOD.
- `clk` input, 1 bit: single system clock. All logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: enables period counting and tick generation.
- `clr_flags` input, 1 bit: synchronous clear of the sticky flags.
- `in_valid` input, 1 bit: upstream sample valid.
- `in_data` input, 16 bits: upstream sample, signed two's complement.
- `in_ready` output, 1 bit: holding register empty. Equal to `!hold_full`, registered state.
- `dac_sample_rdy` output, 1 bit: one-cycle start pulse to the serializer.
- `dac_data` output, 16 bits: sample presented to the serializer.
- `dac_shift_done` input, 1 bit: serializer completion pulse.
- `busy` output, 1 bit: state is not IDLE.
- `tick` output, 1 bit: period strobe, one cycle wide.
- `underrun` output, 1 bit: sticky. Set when a tick finds the holding register empty.
- `overrun` output, 1 bit: sticky. Set when a tick arrives while a transfer is in progress.
- `fault` output, 1 bit: sticky. Set when the WAIT_DONE timeout expires.

## Operation
- Reset values (`rst` = 0): every output is 0, `cnt` = 0, `hold_reg` = 0, `hold_full` = 0, state = IDLE, `dac_data` = 0.
  - Release takes effect at the next clk edge.
  - Asserting reset mid-transfer aborts it immediately with no pulse.
- Period counter `cnt`, 16 bits:
  - `en` = 1: counts 0..PERIOD-1 and wraps to 0.
  - `en` = 0: `cnt` is forced to 0.
  - `tick` = `en && cnt == PERIOD-1` (combinational from registers).
- Upstream handshake:
  - Transfer occurs when `in_valid && in_ready`; then `hold_reg <= in_data` and `hold_full <= 1`.
  - `in_data` is ignored when `in_ready` = 0. Upstream must hold its data.
- State machine (Moore outputs):
  - IDLE + `tick`:
    - If `hold_full`: `dac_data <= hold_reg`, `hold_full <= 0`.
    - Otherwise: `dac_data` is unchanged and `underrun <= 1`.
    - Next state ISSUE.
  - ISSUE: `dac_sample_rdy` = 1. Next state WAIT_DONE unconditionally.
  - WAIT_DONE: timeout counter `tcnt` increments each cycle.
    - `dac_shift_done` = 1: go to IDLE, `tcnt <= 0`.
    - Otherwise `tcnt == TIMEOUT-1`: go to IDLE, `fault <= 1`.
- A tick in ISSUE or WAIT_DONE is dropped: `overrun <= 1`, and `hold_reg` is untouched.
- `dac_data` changes only on the IDLE + `tick` edge. It is stable from the `dac_sample_rdy` pulse through `dac_shift_done`.
- Simultaneous events:
  - Tick and handshake in the same cycle with the register empty: there is no bypass. Underrun is flagged, the incoming sample is stored, and it is used at the next tick.
  - The register cannot be full with `in_ready` = 1, so a refill cannot collide with a drain.
  - `clr_flags` and a flag-set event in the same cycle: set wins.
- `en` falling mid-transfer: the transfer completes normally and no new ticks are generated. `hold_reg` is retained.

## Timing
- Tick in cycle N → `dac_data` updated at the end of N → `dac_sample_rdy` high in cycle N+1 only → WAIT_DONE from N+2.
- First tick occurs PERIOD cycles after `en` rises (`cnt` 0 → PERIOD-1).
- Steady state: exactly one `dac_sample_rdy` every PERIOD cycles.
- `in_ready` rises the cycle after the drain edge, so throughput is one sample per period.
- `busy` is high from N+1 through the cycle in which `dac_shift_done` is sampled.

## Test plan
- **Reset:** hold `rst` = 0 mid-WAIT_DONE with non-zero flags → all outputs 0 and no `dac_sample_rdy` until a new tick after release.
- **Steady stream:** PERIOD = 64, a serializer model with done 40 cycles after start, `in_data` = 0x1234, 0x8000, 0x7FFF → `dac_data` takes each value in turn at a tick, pulses are 64 cycles apart, and all flags stay 0.
- **Starvation:** stop `in_valid` after 0x0ABC → the next tick repeats 0x0ABC, `underrun` = 1, and it stays set until `clr_flags`.
- **Overrun:** done delayed 70 cycles with PERIOD = 64 → `overrun` = 1, that tick is dropped, and the held sample is issued at the following tick.
- **Timeout:** `dac_shift_done` never asserted, TIMEOUT = 256 → `fault` = 1 and the block returns to IDLE 256 cycles after WAIT_DONE entry.
- **Simultaneous:** `clr_flags` pulsed in the same cycle as an underrun tick → `underrun` remains 1. `en` dropped mid-transfer → the transfer completes, then no further pulses.
